// File: rtl/filt_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : filt_sched                                                   |
// | Description : Sample FIFO and start/wait/output sequencer in front of the  |
// |               FIR filter datapath. Optional watchdog abort is enabled by   |
// |               defining FILT_SCHED_TIMEOUT_EN.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module filt_sched #(
  parameter int DATA_SIZE    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 255,
  parameter int CNT_SIZE     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic [1:0]           cfg_sel,
  output logic                 f_start,
  output logic [DATA_SIZE-1:0] f_val,
  output logic [1:0]           f_sel,
  input  logic                 f_done,
  input  logic [DATA_SIZE-1:0] f_result,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  output logic [1:0]           m_sel,
  output logic                 busy,
  output logic [CNT_SIZE-1:0]  overrun_cnt,
  output logic                 timeout_err
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_SC_W  = $clog2(START_CYCLES + 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_OUT   = 2'd3;

  logic [1:0]           r_state;
  logic [c_SC_W-1:0]    r_start_cnt;
  logic [DATA_SIZE-1:0] r_f_val;
  logic [1:0]           r_f_sel;
  logic [DATA_SIZE-1:0] r_m_data;
  logic [1:0]           r_m_sel;
  logic [CNT_SIZE-1:0]  r_overrun_cnt;

  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W:0]     r_wr_ptr;
  logic [c_PTR_W:0]     r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_abort;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_pop   = (r_state == c_ST_IDLE) && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = s_valid && (!w_full || w_pop);
  assign w_drop  = s_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_PTR_W-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun_cnt <= '0;
    end else if (w_drop && (r_overrun_cnt != {CNT_SIZE{1'b1}})) begin
      r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end
  end

`ifdef FILT_SCHED_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT + 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_timeout_err;

  // f_done has priority over the watchdog in the same cycle.
  assign w_abort = (r_state == c_ST_WAIT) && !f_done &&
                   (r_to_cnt == c_TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state != c_ST_WAIT) || f_done || w_abort) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_start_cnt <= '0;
      r_f_val     <= '0;
      r_f_sel     <= 2'b00;
      r_m_data    <= '0;
      r_m_sel     <= 2'b00;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_pop) begin
            r_f_val     <= r_mem[r_rd_ptr[c_PTR_W-1:0]];
            r_f_sel     <= cfg_sel;
            r_start_cnt <= '0;
            r_state     <= c_ST_START;
          end
        end
        c_ST_START: begin
          if (r_start_cnt == c_SC_W'(START_CYCLES - 1)) begin
            r_start_cnt <= '0;
            r_state     <= c_ST_WAIT;
          end else begin
            r_start_cnt <= r_start_cnt + 1'b1;
          end
        end
        c_ST_WAIT: begin
          if (f_done) begin
            r_m_data <= f_result;
            r_m_sel  <= r_f_sel;
            r_state  <= c_ST_OUT;
          end else if (w_abort) begin
            r_state <= c_ST_IDLE;
          end
        end
        c_ST_OUT: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign f_start     = (r_state == c_ST_START);
  assign f_val       = r_f_val;
  assign f_sel       = r_f_sel;
  assign m_valid     = (r_state == c_ST_OUT);
  assign m_data      = r_m_data;
  assign m_sel       = r_m_sel;
  assign busy        = (r_state != c_ST_IDLE) || !w_empty;
  assign overrun_cnt = r_overrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_filt_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_filt_sched                                                |
// | Description : Scoreboard bench for filt_sched with a behavioural datapath. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_filt_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [1:0]  cfg_sel = 2'b00;
  logic        f_start;
  logic [15:0] f_val;
  logic [1:0]  f_sel;
  logic        f_done = 1'b0;
  logic [15:0] f_result = '0;
  logic        m_valid;
  logic [15:0] m_data;
  logic [1:0]  m_sel;
  logic        busy;
  logic [15:0] overrun_cnt;
  logic        timeout_err;

  filt_sched dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .cfg_sel(cfg_sel),
    .f_start(f_start), .f_val(f_val), .f_sel(f_sel), .f_done(f_done),
    .f_result(f_result), .m_valid(m_valid), .m_data(m_data), .m_sel(m_sel),
    .busy(busy), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [1:0]  s;
    int          c;
  } exp_t;
  exp_t sb[$];

  // Datapath model: 0 = bypass, 1 = done after dp_delay WAIT cycles, 2 = stalled
  int          dp_mode   = 0;
  int          dp_delay  = 0;
  bit          dp_inject = 0;
  logic [15:0] mask      = '0;
  bit          md_prev_fs = 0;
  bit          md_in_wait = 0;
  int          md_wcnt    = 0;

  always @(negedge clk) begin
    if (rst) begin
      md_in_wait = 0;
      md_wcnt    = 0;
    end else if (f_start) begin
      md_in_wait = 0;
      md_wcnt    = 0;
    end else if (md_prev_fs) begin
      md_in_wait = 1;
      md_wcnt    = 0;
    end else if (md_in_wait) begin
      md_wcnt++;
    end
    md_prev_fs = f_start;
    f_result   = f_val ^ mask;
    case (dp_mode)
      0: f_done = 1'b1;
      1: begin
        if (f_start) begin
          f_done = dp_inject;
        end else if (md_in_wait && md_wcnt >= dp_delay) begin
          f_done     = 1'b1;
          md_in_wait = 0;
        end else begin
          f_done = 1'b0;
        end
      end
      default: f_done = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop, start pulse width, f_val/f_sel stability
  exp_t        mon_e;
  bit          mon_prev_fs = 0;
  bit          mon_fl = 0;
  int          mon_run = 0;
  logic [15:0] mon_val;
  logic [1:0]  mon_sel;

  always @(negedge clk) begin
    if (rst) begin
      mon_fl      = 0;
      mon_run     = 0;
      mon_prev_fs = 0;
    end else begin
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("unexp_mvalid", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("m_data", 32'(m_data), 32'(mon_e.d));
          chk("m_sel", 32'(m_sel), 32'(mon_e.s));
          if (mon_e.c >= 0) chk("m_cyc", cyc, mon_e.c);
        end
      end
      if (f_start && !mon_prev_fs) begin
        mon_fl  = 1;
        mon_val = f_val;
        mon_sel = f_sel;
      end else if (mon_fl) begin
        chk("fval_stable", 32'(f_val), 32'(mon_val));
        chk("fsel_stable", 32'(f_sel), 32'(mon_sel));
      end
      if (m_valid || !busy) mon_fl = 0;
      if (f_start) begin
        mon_run++;
      end else if (mon_prev_fs) begin
        chk("start_len", mon_run, 2);
        mon_run = 0;
      end
      mon_prev_fs = f_start;
    end
  end

  // Drives one sample for one cycle; off < 0 means the output cycle is not checked.
  task automatic send(input logic [15:0] d, input logic [1:0] s, input int off, input bit expect_out);
    exp_t e;
    s_valid = 1'b1;
    s_data  = d;
    if (expect_out) begin
      e.d = d ^ mask;
      e.s = s;
      e.c = (off < 0) ? -1 : cyc + off;
      sb.push_back(e);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_f_start", 32'(f_start), 0);
    chk("rst_f_val", 32'(f_val), 0);
    chk("rst_f_sel", 32'(f_sel), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_sel", 32'(m_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    chk("rst_timeout", 32'(timeout_err), 0);

    // Bypass: minimum latency
    dp_mode = 0; mask = '0; cfg_sel = 2'b11;
    send(16'h1234, 2'b11, 5, 1);
    chk("byp_fs_c1", 32'(f_start), 0);
    @(negedge clk); chk("byp_fs_c2", 32'(f_start), 1);
    @(negedge clk); chk("byp_fs_c3", 32'(f_start), 1);
    @(negedge clk); chk("byp_fs_c4", 32'(f_start), 0);
    drain(50);

    // Filter handshake: done 10 cycles after WAIT entry, pulses during START
    dp_mode = 1; dp_delay = 10; dp_inject = 1; mask = 16'hFFFF; cfg_sel = 2'b00;
    send(16'hF0F0, 2'b00, 15, 1);
    drain(60);
    dp_inject = 0;

    // Select latch: cfg_sel changes while A is in WAIT, B already queued
    dp_delay = 6; mask = 16'h00FF; cfg_sel = 2'b00;
    send(16'hAAAA, 2'b00, 11, 1);
    send(16'hBBBB, 2'b01, 21, 1);
    repeat (2) @(negedge clk);
    cfg_sel = 2'b01;
    drain(80);

    // Overrun: 12 samples while stalled
    dp_mode = 2; mask = '0; cfg_sel = 2'b10;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0100 + 16'(i);
      if (i < 9) sb.push_back('{16'h0100 + 16'(i), 2'b10, -1});
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("overrun_cnt", 32'(overrun_cnt), 3);
    chk("overrun_busy", 32'(busy), 1);
    dp_mode = 1; dp_delay = 0;
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_first_out", 32'(m_valid), 1);
    @(negedge clk);
    send(16'h01FF, 2'b10, -1, 1);
    chk("ovr_full_pushpop", 32'(overrun_cnt), 3);
    drain(200);

    // Watchdog behaviour with the datapath stalled
    dp_mode = 2; cfg_sel = 2'b00;
    send(16'hDEAD, 2'b00, -1, 0);
`ifdef FILT_SCHED_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_err_set", 32'(timeout_err), 1);
    chk("to_idle", 32'(busy), 0);
    dp_mode = 0;
    send(16'h5A5A, 2'b00, 5, 1);
    drain(50);
    chk("to_err_sticky", 32'(timeout_err), 1);
    dp_mode = 2;
    send(16'hDEAD, 2'b00, -1, 0);
`else
    repeat (300) @(negedge clk);
    chk("noto_err", 32'(timeout_err), 0);
    chk("noto_busy", 32'(busy), 1);
`endif

    // Reset while in WAIT with another sample queued
    send(16'hBEEF, 2'b00, -1, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_m_valid", 32'(m_valid), 0);
    chk("rstw_timeout", 32'(timeout_err), 0);
    rst = 1'b0;
    dp_mode = 0;
    repeat (20) @(negedge clk);
    chk("rstw_idle", 32'(busy), 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
